// File: rtl/led_pwm_pkg.sv
// led_pwm_pkg
//   Shared definitions for the LED output stage: the layout of the SoC LED
//   word (mode bit, duty field width), the mode encoding, and a helper that
//   pulls one channel's duty field out of a 32-bit LED word.
package led_pwm_pkg;

  // Bit 31 of the SoC LED word selects how the rest of the word is read.
  localparam int LED_MODE_BIT = 31;

  // Width of one channel's duty field in PWM mode.
  localparam int LED_DUTY_W = 4;

  typedef enum logic {
    LED_MODE_LEGACY = 1'b0,  // leds[i] is the on/off state of channel i
    LED_MODE_PWM    = 1'b1   // leds[4i+3:4i] is the duty of channel i
  } led_mode_e;

  // Duty field of channel i: word[4i+3:4i].
  function automatic logic [LED_DUTY_W-1:0] duty_of(input logic [31:0] word,
                                                    input int unsigned i);
    logic [4:0] lsb;
    lsb = 5'(i * LED_DUTY_W);
    return word[lsb +: LED_DUTY_W];
  endfunction

endpackage

// File: rtl/led_pwm_timebase.sv
// led_pwm_timebase
//   Prescaler plus PWM phase counter. The prescaler divides the system clock
//   down to one tick every PRESCALE cycles; the phase counter steps on each
//   tick through 0..2^DUTY_W-2, so a full PWM period is
//   (2^DUTY_W-1)*PRESCALE cycles.
//
// Ports
//   clock    : system clock, rising edge
//   reset    : synchronous active-high reset, clears both counters
//   tick     : high while the prescaler sits at its last count
//   phase    : current PWM phase, 0..2^DUTY_W-2
//   boundary : tick on the last phase; the cycle whose edge starts a period
module led_pwm_timebase #(
  parameter int PRESCALE = 750,
  parameter int DUTY_W   = 4
) (
  input  logic              clock,
  input  logic              reset,
  output logic              tick,
  output logic [DUTY_W-1:0] phase,
  output logic              boundary
);

  localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);
  // The phase stops one short of all-ones so that a full-scale duty value
  // (all-ones) compares greater than every phase and reads as always-on.
  localparam logic [DUTY_W-1:0] PHASE_LAST = DUTY_W'((1 << DUTY_W) - 2);

  logic [PS_W-1:0]   prescale_reg;
  logic [DUTY_W-1:0] phase_reg;

  assign tick     = (prescale_reg == PS_LAST);
  assign boundary = tick && (phase_reg == PHASE_LAST);
  assign phase    = phase_reg;

  always_ff @(posedge clock) begin
    if (reset) begin
      prescale_reg <= '0;
      phase_reg    <= '0;
    end else begin
      if (tick) begin
        prescale_reg <= '0;
      end else begin
        prescale_reg <= prescale_reg + PS_W'(1);
      end

      if (boundary) begin
        phase_reg <= '0;
      end else if (tick) begin
        phase_reg <= phase_reg + DUTY_W'(1);
      end
    end
  end

endmodule

// File: rtl/led_pwm.sv
// led_pwm
//   LED output stage between the SoC LED register and the board LED pins.
//   The SoC word is captured into a shadow register only at the PWM period
//   boundary, so a write never tears a period. Each channel is then driven
//   either on/off (legacy mode) or by comparing the running phase against a
//   4-bit duty (PWM mode). Per-pin polarity is applied last, so software
//   always writes "1 = lit".
//
// Ports
//   clock        : system clock, rising edge
//   reset        : synchronous active-high reset; pins go dark
//   leds         : SoC LED word; bit 31 = mode, bits 30:28 ignored
//   led_out      : registered pin drive, polarity applied
//   period_start : one-cycle pulse the cycle after the shadow reload
module led_pwm
  import led_pwm_pkg::*;
#(
  parameter int                   NUM_LEDS   = 7,
  parameter int                   DUTY_W     = 4,
  parameter int                   PRESCALE   = 750,
  parameter logic [NUM_LEDS-1:0]  ACTIVE_LOW = 7'b1100000
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [31:0]         leds,
  output logic [NUM_LEDS-1:0] led_out,
  output logic                period_start
);

  logic              tick;
  logic [DUTY_W-1:0] phase;
  logic              boundary;

  logic [31:0]         shadow_reg;
  logic [NUM_LEDS-1:0] led_out_reg;
  logic                period_start_reg;

  led_mode_e           shadow_mode;
  logic [NUM_LEDS-1:0] on_vec;
  logic [NUM_LEDS-1:0] pin_next;

  // The tick itself is only needed inside the timebase, and not every
  // shadow bit feeds a channel (bits 30:28 never do); folding them here
  // documents that they are intentionally left unused.
  logic unused_ok;
  assign unused_ok = ^{tick, shadow_reg};

  led_pwm_timebase #(
    .PRESCALE (PRESCALE),
    .DUTY_W   (DUTY_W)
  ) u_timebase (
    .clock    (clock),
    .reset    (reset),
    .tick     (tick),
    .phase    (phase),
    .boundary (boundary)
  );

  assign shadow_mode = led_mode_e'(shadow_reg[LED_MODE_BIT]);

  // Per-channel compare. Duty 0 never beats any phase (always off) and the
  // all-ones duty beats every phase (always on).
  generate
    for (genvar gi = 0; gi < NUM_LEDS; gi++) begin : g_chan
      logic [DUTY_W-1:0] duty;
      assign duty = DUTY_W'(duty_of(shadow_reg, gi));
      assign on_vec[gi] = (shadow_mode == LED_MODE_PWM) ? (phase < duty)
                                                         : shadow_reg[gi];
    end
  endgenerate

  assign pin_next = on_vec ^ ACTIVE_LOW;

  // The output register samples the old shadow on the boundary edge, so new
  // contents reach the pins one edge later, together with phase 0.
  always_ff @(posedge clock) begin
    if (reset) begin
      shadow_reg       <= '0;
      led_out_reg      <= ACTIVE_LOW;
      period_start_reg <= 1'b0;
    end else begin
      led_out_reg      <= pin_next;
      period_start_reg <= boundary;
      if (boundary) begin
        shadow_reg <= leds;
      end
    end
  end

  assign led_out      = led_out_reg;
  assign period_start = period_start_reg;

endmodule

// File: tb/tb_led_pwm.sv
// tb_led_pwm
//   Self-checking bench for led_pwm with PRESCALE=2, DUTY_W=4 (30-cycle
//   period). A cycle-count based reference model predicts led_out and
//   period_start on every edge; table vectors and hand sequences add
//   direct checks of the documented scenarios.
module tb_led_pwm;

  localparam int NUM_LEDS = 7;
  localparam int DUTY_W   = 4;
  localparam int PRESCALE = 2;
  localparam logic [NUM_LEDS-1:0] AL = 7'b1100000;
  localparam int PERIOD = ((1 << DUTY_W) - 1) * PRESCALE;  // 30

  logic                clock = 1'b0;
  logic                reset;
  logic [31:0]         leds;
  logic [NUM_LEDS-1:0] led_out;
  logic                period_start;

  int checks = 0;
  int errors = 0;

  // Reference model state
  int unsigned         n_edges;   // non-reset edges since the last reset
  logic [31:0]         m_shadow;
  logic [NUM_LEDS-1:0] m_led;
  logic                m_ps;

  typedef struct {
    logic [31:0]         word;
    logic [NUM_LEDS-1:0] exp;
  } vec_t;

  vec_t vecs[7];

  led_pwm #(
    .NUM_LEDS   (NUM_LEDS),
    .DUTY_W     (DUTY_W),
    .PRESCALE   (PRESCALE),
    .ACTIVE_LOW (AL)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .leds         (leds),
    .led_out      (led_out),
    .period_start (period_start)
  );

  always #5 clock = ~clock;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Pin pattern for a given shadow word and phase, straight from the rules:
  // legacy uses bit i, PWM lights a channel while phase < duty.
  function automatic logic [NUM_LEDS-1:0] model_pins(input logic [31:0] sh,
                                                     input int ph);
    logic [NUM_LEDS-1:0] r;
    logic on;
    int d;
    r = '0;
    for (int i = 0; i < NUM_LEDS; i++) begin
      d  = int'((sh >> (4 * i)) & 32'hF);
      on = sh[31] ? (ph < d) : sh[i];
      r[i] = on ^ AL[i];
    end
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock edge with the given inputs; the model advances and both
  // outputs are compared 1 time unit after the edge.
  task automatic step(input logic rst, input logic [31:0] w);
    int idx;
    reset = rst;
    leds  = w;
    @(posedge clock);
    if (rst) begin
      n_edges  = 0;
      m_shadow = '0;
      m_led    = AL;
      m_ps     = 1'b0;
    end else begin
      idx   = int'(n_edges % PERIOD);
      m_led = model_pins(m_shadow, idx / PRESCALE);
      m_ps  = (idx == PERIOD - 1);
      if (m_ps) m_shadow = w;
      n_edges++;
    end
    #1;
    check("model_pins", 32'(led_out), 32'(m_led));
    check("model_period_start", 32'(period_start), 32'(m_ps));
  endtask

  // Run until the model's boundary edge (word gets loaded there).
  task automatic wait_ps(input logic [31:0] w);
    int k;
    k = 0;
    do begin
      step(1'b0, w);
      k++;
    end while (!m_ps && k < 4 * PERIOD);
    if (!m_ps) begin
      checks++;
      errors++;
      $display("FAIL wait_ps: no period boundary within %0d cycles", k);
    end
  endtask

  initial begin
    int cnt;
    int hi0, hi1, bad;
    logic [31:0] w;
    logic rst;

    vecs[0] = '{32'h0000_0055, 7'b0110101};
    vecs[1] = '{32'h0000_007F, 7'b0011111};
    vecs[2] = '{32'h0000_0000, 7'b1100000};
    vecs[3] = '{32'h7000_002A, 7'b1001010};  // bits 30:28 ignored
    vecs[4] = '{32'h0FFF_FF80, 7'b1100000};  // bits 27:7 ignored in legacy
    vecs[5] = '{32'h8000_0000, 7'b1100000};  // PWM, every duty 0
    vecs[6] = '{32'h8FFF_FFFF, 7'b0011111};  // PWM, every duty 15

    // Reset held for 5 cycles, then time to the first period_start
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 32'h0);
      check("reset_pins", 32'(led_out), 32'(AL));
    end
    cnt = 0;
    do begin
      step(1'b0, 32'h0);
      cnt++;
    end while (!period_start && cnt < 100);
    check("first_ps_cycles", cnt, 30);
    $display("reset: first period_start after %0d cycles", cnt);

    // Table-driven steady-state vectors, three periods each
    foreach (vecs[v]) begin
      wait_ps(vecs[v].word);
      bad = 0;
      for (int c = 0; c < 3 * PERIOD; c++) begin
        step(1'b0, vecs[v].word);
        if (led_out !== vecs[v].exp) bad++;
      end
      check("steady_vector", bad, 0);
      $display("vector %0d: leds=%h pins=%b", v, vecs[v].word, led_out);
    end

    // PWM channel 0 at duty 8
    wait_ps(32'h8000_0008);
    hi0 = 0; bad = 0;
    for (int c = 0; c < PERIOD; c++) begin
      step(1'b0, 32'h8000_0008);
      if (c == 0) check("pwm8_first_high", 32'(led_out[0]), 32'd1);
      if (led_out[0]) hi0++;
      if (led_out[6:1] !== AL[6:1]) bad++;
    end
    check("pwm8_high_cycles", hi0, 16);
    check("pwm8_others_dark", bad, 0);
    $display("pwm duty 8: ch0 high %0d of %0d cycles", hi0, PERIOD);

    // Extremes: ch1 duty 14, ch6 duty 15, others 0
    wait_ps(32'h8F00_00E0);
    hi1 = 0; bad = 0;
    for (int c = 0; c < PERIOD; c++) begin
      step(1'b0, 32'h8F00_00E0);
      if (led_out[1]) hi1++;
      if (led_out[6] !== 1'b0 || led_out[0] !== 1'b0) bad++;
    end
    check("duty14_high_cycles", hi1, 28);
    check("duty15_and_duty0_steady", bad, 0);
    $display("extremes: ch1 high %0d of %0d cycles", hi1, PERIOD);

    // Mid-period change at phase 5 is deferred to the next boundary
    wait_ps(32'h0);
    for (int c = 0; c < 5 * PRESCALE; c++) step(1'b0, 32'h0);
    bad = 0; cnt = 0;
    do begin
      step(1'b0, 32'h0000_007F);
      cnt++;
      if (led_out !== AL) bad++;
    end while (!period_start && cnt < 100);
    check("midchange_held", bad, 0);
    check("midchange_ps_seen", 32'(period_start), 32'd1);
    step(1'b0, 32'h0000_007F);
    check("midchange_applied", 32'(led_out), 32'(7'b0011111));
    $display("mid-period change: pins=%b after %0d cycles", led_out, cnt);

    // Reset pulse at phase 7 with all LEDs lit
    wait_ps(32'h0000_007F);
    for (int c = 0; c < 7 * PRESCALE; c++) step(1'b0, 32'h0000_007F);
    check("lit_before_reset", 32'(led_out), 32'(7'b0011111));
    step(1'b1, 32'h0000_007F);
    check("midreset_pins", 32'(led_out), 32'(AL));
    bad = 0; cnt = 0;
    do begin
      step(1'b0, 32'h0000_007F);
      cnt++;
      if (led_out !== AL) bad++;
    end while (!period_start && cnt < 100);
    check("midreset_shadow_cleared", bad, 0);
    check("midreset_ps_cycles", cnt, 30);
    step(1'b0, 32'h0000_007F);
    check("midreset_reload", 32'(led_out), 32'(7'b0011111));
    $display("reset mid-period: next period_start after %0d cycles", cnt);

    // Randomized words and occasional resets against the model
    w = $urandom;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 19) == 0) w = $urandom;
      rst = ($urandom_range(0, 299) == 0);
      step(rst, w);
    end
    $display("random: 3000 cycles compared against the model");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/led_pwm.md
# led_pwm

LED output stage placed directly downstream of `nervsoc` in board tops, between the SoC `leds[31:0]` register and the board LED pins. It latches the SoC LED word once per PWM period, so updates are glitch-free. It drives each LED either on/off (legacy mode) or with a 4-bit duty cycle (PWM mode). Per-pin output polarity is applied so software always writes "1 = lit".

## Interface
- `NUM_LEDS`, 7: number of LED channels driven.
- `DUTY_W`, 4: duty field width per channel.
- `PRESCALE`, 750: clock cycles per PWM tick; must be ≥ 2.
- `ACTIVE_LOW`, 7'b1100000: per-channel inversion mask. Bits 6 and 5 correspond to the LEDR_N and LEDG_N pins.
- `clock` input 1: single system clock. All logic is on its rising edge.
- `reset` input 1: synchronous, active-high reset.
- `leds` input 32: SoC LED word (format below). May change on any cycle.
- `led_out` output NUM_LEDS: registered pin drive, polarity already applied.
- `period_start` output 1: one-cycle pulse on the cycle after the shadow register is reloaded.

## Operation
- **LED word format**
  - bit 31 = mode: 0 selects legacy mode, 1 selects PWM mode.
  - Legacy mode: `leds[i]` is the on/off state of channel i.
  - PWM mode: `leds[4i+3:4i]` is the duty of channel i, for i = 0..6, occupying bits [27:0].
  - Bits 30:28 are always ignored. Bits 27:7 are ignored in legacy mode.
- **Prescaler**
  - Counts 0..PRESCALE-1 and wraps.
  - `tick` is asserted while the count equals PRESCALE-1.
  - Width is $clog2(PRESCALE).
- **Phase counter**
  - DUTY_W bits wide; counts 0..PMAX, where PMAX = 2^DUTY_W − 2 (14 by default).
  - Advances on `tick`.
  - On `tick` with phase == PMAX it wraps to 0; this is the "boundary".
  - One PWM period = (PMAX+1)·PRESCALE cycles.
- **Shadow register**
  - 32 bits.
  - Loaded from `leds` only on the boundary cycle.
  - Changes to `leds` at any other time have no effect until the next boundary.
- **Logical on, channel i**
  - Legacy mode: shadow[i].
  - PWM mode: phase < duty_i.
  - Resulting duty behaviour: duty 0 is always off; duty ≥ 2^DUTY_W−1 (15) is always on; duty d lit for d of 15 ticks.
- **Output:** `led_out[i]` <= on_i XOR ACTIVE_LOW[i], registered.
- **Reset**, synchronous, any cycle including mid-period. On the next edge:
  - prescaler, phase and shadow are cleared to 0;
  - `period_start` = 0;
  - `led_out` = ACTIVE_LOW, i.e. all LEDs dark.
- **State:** no FSM beyond the two counters. Legacy and PWM modes share the same datapath.

## Timing
- Boundary edge at cycle t updates all of the following together:
  - phase <= 0;
  - shadow <= `leds`(t);
  - `period_start` <= 1, for exactly one cycle.
- `led_out` at t+1 = f(shadow(t), phase(t)).
  - New shadow contents therefore appear on the pins at the edge after the boundary edge, aligned with the `period_start` high cycle +1.
- Worst-case latency from a change on `leds` to the pins is one period + 2 cycles.
- First boundary after reset release: (PMAX+1)·PRESCALE cycles after the first non-reset edge.
- Simultaneous reset and boundary: reset wins. No shadow load and no pulse occur.
- Phase and prescaler both wrap at their maxima; no counter saturates or overflows.

## Structure
- Shared package/header `led_pwm_pkg` holds:
  - `LED_MODE_BIT` = 31;
  - `LED_DUTY_W` = 4;
  - function `duty_of(word, i)` that extracts `word[4i+3:4i]`.
- Sub-module `led_pwm_timebase`:
  - contains the prescaler and phase counter;
  - outputs `tick`, `phase`, `boundary`.
- `led_pwm` holds the shadow register, the per-channel compare logic, the polarity XOR and the output register.

## Test plan
All tests use PRESCALE=2 and DUTY_W=4, giving a 30-cycle period.
- **Reset:** hold reset for 5 cycles, then release.
  - During and after reset, `led_out` = 7'b1100000.
  - First `period_start` pulse occurs exactly 30 cycles after release.
- **Legacy mode:** drive `leds` = 32'h0000_0055.
  - After the next `period_start`, `led_out` = 7'b0110101 and stays steady for 3 periods.
- **PWM mode:** drive `leds` = 32'h8000_0008 (channel 0, duty 8).
  - `led_out[0]` is high for 16 of 30 cycles per period, starting 1 cycle after the `period_start` rise.
  - All other channels stay dark.
- **Extremes:** drive `leds` = 32'h8F00_00E0, giving ch1 duty 14, ch6 duty 15, others duty 0.
  - `led_out[1]` is high for 28 of 30 cycles.
  - `led_out[6]` is steadily 0 (lit, active-low).
  - ch0 is steadily 0.
- **Mid-period change:** change `leds` from 32'h0 to 32'h0000_007F at phase 5.
  - `led_out` does not change until 1 cycle after the next `period_start`, then becomes 7'b0011111.
- **Reset mid-period:** pulse reset for 1 cycle at phase 7 with LEDs lit.
  - Next cycle `led_out` = 7'b1100000.
  - Shadow is cleared.
  - Next `period_start` occurs 30 cycles after reset deassertion.
